// File: rtl/lbist_sequencer.sv
// Logic-BIST run sequencer: steps seed load, scan shift/capture per pattern,
// a final unload flush and a signature compare, all with registered Moore outputs.
module lbist_sequencer #(
  parameter int CHAIN_LEN         = 24,
  parameter int PATTERNS_PER_SEED = 200,
  parameter int SEED_NUM          = 10,
  parameter int MISR_W            = 16,
  parameter int MISR_GOLDEN       = 13984,
  localparam int SEED_W           = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [MISR_W-1:0] misr_sig_i,
  output logic              test_mode_o,
  output logic              lbist_en_o,
  output logic              scan_en_o,
  output logic              seed_load_o,
  output logic [SEED_W-1:0] seed_idx_o,
  output logic              lfsr_en_o,
  output logic              misr_clr_o,
  output logic              misr_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              go_nogo_o
);

  localparam int SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PAT_W = (PATTERNS_PER_SEED > 1) ? $clog2(PATTERNS_PER_SEED) : 1;

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(PATTERNS_PER_SEED - 1);
  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_NUM - 1);
  localparam logic [MISR_W-1:0] GOLDEN    = MISR_W'(MISR_GOLDEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_FLUSH,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [SH_W-1:0]    r_shift;
  logic [PAT_W-1:0]   r_pat;
  logic [SEED_W-1:0]  r_seed;

  state_t             w_state_nx;
  logic [SH_W-1:0]    w_shift_nx;
  logic [PAT_W-1:0]   w_pat_nx;
  logic [SEED_W-1:0]  w_seed_nx;
  logic               w_run_nx;

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_pat_nx   = r_pat;
    w_seed_nx  = r_seed;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) w_state_nx = ST_INIT;
      end
      ST_INIT: begin
        w_seed_nx  = '0;
        w_pat_nx   = '0;
        w_shift_nx = '0;
        w_state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        w_shift_nx = '0;
        w_state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_shift == SH_LAST) begin
          w_shift_nx = '0;
          w_state_nx = ST_CAPTURE;
        end else begin
          w_shift_nx = r_shift + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (r_pat != PAT_LAST) begin
          w_pat_nx   = r_pat + 1'b1;
          w_state_nx = ST_SHIFT;
        end else if (r_seed != SEED_LAST) begin
          w_seed_nx  = r_seed + 1'b1;
          w_pat_nx   = '0;
          w_state_nx = ST_LOAD;
        end else begin
          w_state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_shift == SH_LAST) begin
          w_shift_nx = '0;
          w_state_nx = ST_COMPARE;
        end else begin
          w_shift_nx = r_shift + 1'b1;
        end
      end
      ST_COMPARE: w_state_nx = ST_DONE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  assign w_run_nx = (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);

  // Outputs are registered from the next-state decode, so they line up
  // cycle-for-cycle with the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_pat       <= '0;
      r_seed      <= '0;
      test_mode_o <= 1'b0;
      lbist_en_o  <= 1'b0;
      scan_en_o   <= 1'b0;
      seed_load_o <= 1'b0;
      seed_idx_o  <= '0;
      lfsr_en_o   <= 1'b0;
      misr_clr_o  <= 1'b0;
      misr_en_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      go_nogo_o   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_shift     <= w_shift_nx;
      r_pat       <= w_pat_nx;
      r_seed      <= w_seed_nx;
      test_mode_o <= w_run_nx;
      lbist_en_o  <= w_run_nx;
      busy_o      <= w_run_nx;
      scan_en_o   <= (w_state_nx == ST_SHIFT) || (w_state_nx == ST_FLUSH);
      misr_en_o   <= (w_state_nx == ST_SHIFT) || (w_state_nx == ST_FLUSH);
      lfsr_en_o   <= (w_state_nx == ST_SHIFT);
      seed_load_o <= (w_state_nx == ST_LOAD);
      seed_idx_o  <= w_run_nx ? w_seed_nx : '0;
      misr_clr_o  <= (w_state_nx == ST_INIT);
      done_o      <= (w_state_nx == ST_DONE);
      if (w_state_nx == ST_INIT) begin
        go_nogo_o <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
        go_nogo_o <= (misr_sig_i == GOLDEN);
      end
    end
  end

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer: a 4/2/2 instance for timing, counts,
// pass/fail and reset behaviour, and a 1/1/1 instance traced state by state.
module tb_lbist_sequencer;

  localparam int        GOLD   = 13984;
  localparam logic [15:0] GOLD16 = 16'(GOLD);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: CHAIN_LEN=4, PATTERNS_PER_SEED=2, SEED_NUM=2
  logic        a_start;
  logic [15:0] a_misr;
  logic        a_tm, a_le, a_scan, a_load, a_lfsr, a_clr, a_men, a_busy, a_done, a_go;
  logic [0:0]  a_idx;

  lbist_sequencer #(
    .CHAIN_LEN(4), .PATTERNS_PER_SEED(2), .SEED_NUM(2), .MISR_W(16), .MISR_GOLDEN(GOLD)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .misr_sig_i(a_misr),
    .test_mode_o(a_tm), .lbist_en_o(a_le), .scan_en_o(a_scan), .seed_load_o(a_load),
    .seed_idx_o(a_idx), .lfsr_en_o(a_lfsr), .misr_clr_o(a_clr), .misr_en_o(a_men),
    .busy_o(a_busy), .done_o(a_done), .go_nogo_o(a_go)
  );

  // Instance B: all counts = 1
  logic        b_start;
  logic [15:0] b_misr;
  logic        b_tm, b_le, b_scan, b_load, b_lfsr, b_clr, b_men, b_busy, b_done, b_go;
  logic [0:0]  b_idx;

  lbist_sequencer #(
    .CHAIN_LEN(1), .PATTERNS_PER_SEED(1), .SEED_NUM(1), .MISR_W(16), .MISR_GOLDEN(GOLD)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .misr_sig_i(b_misr),
    .test_mode_o(b_tm), .lbist_en_o(b_le), .scan_en_o(b_scan), .seed_load_o(b_load),
    .seed_idx_o(b_idx), .lfsr_en_o(b_lfsr), .misr_clr_o(b_clr), .misr_en_o(b_men),
    .busy_o(b_busy), .done_o(b_done), .go_nogo_o(b_go)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] a_vec();
    return {21'd0, a_tm, a_le, a_scan, a_load, a_idx, a_lfsr, a_clr, a_men, a_busy, a_done, a_go};
  endfunction

  function automatic logic [7:0] b_vec();
    return {b_busy, b_tm, b_clr, b_load, b_scan, b_lfsr, b_men, b_done};
  endfunction

  // Pulses start (optionally holding it) and measures one run of instance A.
  // k=0 is the cycle right after the edge that sampled start.
  task automatic run_a(input bit hold, output int lat, output int n_scan, output int n_lfsr,
                       output int n_men, output int n_load, output int n_clr, output int n_tm,
                       output int idx0, output int idx1, output logic go_init,
                       output logic go_done);
    lat = -1; n_scan = 0; n_lfsr = 0; n_men = 0; n_load = 0; n_clr = 0; n_tm = 0;
    idx0 = -1; idx1 = -1; go_done = 1'bx;
    a_start = 1'b1;
    tick();
    if (!hold) a_start = 1'b0;
    go_init = a_go;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) tick();
      if (a_done) begin
        lat     = k;
        go_done = a_go;
        break;
      end
      n_scan += int'(a_scan);
      n_lfsr += int'(a_lfsr);
      n_men  += int'(a_men);
      n_clr  += int'(a_clr);
      n_tm   += int'(a_tm & a_le);
      if (a_load) begin
        if (n_load == 0) idx0 = int'(a_idx);
        else             idx1 = int'(a_idx);
        n_load++;
      end
    end
  endtask

  int   lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1;
  logic go_init, go_done;

  // INIT, LOAD, SHIFT, CAPTURE, FLUSH, COMPARE, DONE as {busy,tm,clr,load,scan,lfsr,men,done}
  logic [7:0] b_exp [7] = '{8'b1110_0000, 8'b1101_0000, 8'b1100_1110, 8'b1100_0000,
                            8'b1100_1010, 8'b1100_0000, 8'b0000_0001};

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_misr  = GOLD16;
    b_misr  = GOLD16;
    #23;
    check_val("reset_outputs", a_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("idle_after_reset", a_vec(), 32'd0);
    end

    // Passing run: 28-cycle latency, 20 scan cycles, two seed loads 0 then 1
    run_a(1'b0, lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1, go_init, go_done);
    check_val("run1_latency", lat, 28);
    check_val("run1_scan_en_cycles", n_scan, 20);
    check_val("run1_lfsr_en_cycles", n_lfsr, 16);
    check_val("run1_misr_en_cycles", n_men, 20);
    check_val("run1_seed_loads", n_load, 2);
    check_val("run1_seed_idx0", idx0, 0);
    check_val("run1_seed_idx1", idx1, 1);
    check_val("run1_misr_clr_pulses", n_clr, 1);
    check_val("run1_test_mode_cycles", n_tm, 28);
    check_val("run1_go_nogo", go_done, 1);
    tick();
    check_val("done_go_held", {a_done, a_go, a_busy, a_tm}, 4'b1100);

    // Failing signature, started from DONE
    a_misr = GOLD16 ^ 16'd1;
    run_a(1'b0, lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1, go_init, go_done);
    check_val("run2_go_cleared_in_init", go_init, 0);
    check_val("run2_latency", lat, 28);
    check_val("run2_go_nogo", go_done, 0);

    // start held high across the run: no restart while busy
    a_misr = GOLD16;
    run_a(1'b1, lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1, go_init, go_done);
    check_val("held_latency", lat, 28);
    check_val("held_misr_clr_pulses", n_clr, 1);
    check_val("held_go_nogo", go_done, 1);
    // Still held in DONE: next edge enters INIT with go cleared and a clear pulse
    run_a(1'b0, lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1, go_init, go_done);
    check_val("restart_go_cleared", go_init, 0);
    check_val("restart_misr_clr", n_clr, 1);
    check_val("restart_latency", lat, 28);

    // Asynchronous reset during the third SHIFT cycle
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("third_shift_scan_en", {a_scan, a_lfsr, a_busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset_outputs", a_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_val("idle_after_midrun_reset", a_vec(), 32'd0);
    run_a(1'b0, lat, n_scan, n_lfsr, n_men, n_load, n_clr, n_tm, idx0, idx1, go_init, go_done);
    check_val("post_reset_latency", lat, 28);
    check_val("post_reset_scan_en_cycles", n_scan, 20);
    check_val("post_reset_go_nogo", go_done, 1);

    // Minimal instance: one cycle per state, DONE five cycles after INIT ends
    check_val("b_idle", b_vec(), 8'd0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      check_val($sformatf("b_state_%0d", k), b_vec(), b_exp[k]);
    end
    check_val("b_go_nogo", b_go, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
